// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I subset control unit.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecuteR,
    StExecuteI,
    StAluWb,
    StBeq,
    StJal
  } statetype;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Maps aluop plus instruction funct fields onto the 3-bit alu control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] aluop,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    unique case (aluop)
      2'b00: alucontrol = ALU_ADD;
      2'b01: alucontrol = ALU_SUB;
      2'b10: begin
        unique case (funct3)
          // Only R-type with funct7b5 set is sub; addi ignores funct7b5.
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle core: Moore datapath strobes plus embedded alu decoder.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic       regwrite,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  statetype   state_q, state_d, out_st;
  logic [1:0] aluop;
  logic       branch, pcupdate;
  logic       memwrite_s, irwrite_s, regwrite_s, illegal_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_R:         state_d = StExecuteR;
          OP_I:         state_d = StExecuteI;
          OP_BEQ:       state_d = StBeq;
          OP_JAL:       state_d = StJal;
          default:      state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (op == OP_LW) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBeq:      state_d = StFetch;
      StJal:      state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // During reset the selects already show FETCH values, so the first cycle is clean.
  assign out_st = reset ? StFetch : state_q;

  always_comb begin
    adrsrc     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    regwrite_s = 1'b0;
    aluop      = 2'b00;
    branch     = 1'b0;
    pcupdate   = 1'b0;
    illegal_s  = 1'b0;
    unique case (out_st)
      StFetch: begin
        irwrite_s = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
      end
      StDecode: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: illegal_s = 1'b0;
          default:                                  illegal_s = 1'b1;
        endcase
      end
      StMemAdr: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      StMemRead: adrsrc = 1'b1;
      StMemWb: begin
        resultsrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      StMemWrite: begin
        adrsrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      StExecuteR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      StExecuteI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      StAluWb: regwrite_s = 1'b1;
      StBeq: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      StJal: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcwrite  = ~reset & (pcupdate | (branch & zero));
  assign memwrite = ~reset & memwrite_s;
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign illegal  = ~reset & illegal_s;

  always_comb begin
    immsrc = 2'b00;
    case (op)
      OP_SW:   immsrc = 2'b01;
      OP_BEQ:  immsrc = 2'b10;
      OP_JAL:  immsrc = 2'b11;
      default: immsrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .op5        (op[5]),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .aluop      (aluop),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: per-instruction cycle sequences compared against a table-driven model.
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic       regwrite;
    logic [2:0] alucontrol;
    logic       illegal;
  } outs_t;

  typedef enum int {SFetch, SDecode, SMemAdr, SMemRead, SMemWb, SMemWrite,
                    SExecR, SExecI, SAluWb, SBeq, SJal} step_t;
  typedef step_t stepq_t[$];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0, zero = 1'b0;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .immsrc     (immsrc),
    .regwrite   (regwrite),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  function automatic bit legal(input logic [6:0] o);
    return o inside {LW, SW, RT, IT, BEQ, JAL};
  endfunction

  // Cycle-by-cycle path of one instruction, from the cycle-count table.
  function automatic stepq_t steps_of(input logic [6:0] o);
    stepq_t q;
    q.push_back(SFetch);
    q.push_back(SDecode);
    if (o == LW) begin q.push_back(SMemAdr); q.push_back(SMemRead); q.push_back(SMemWb); end
    else if (o == SW) begin q.push_back(SMemAdr); q.push_back(SMemWrite); end
    else if (o == RT) begin q.push_back(SExecR); q.push_back(SAluWb); end
    else if (o == IT) begin q.push_back(SExecI); q.push_back(SAluWb); end
    else if (o == JAL) begin q.push_back(SJal); q.push_back(SAluWb); end
    else if (o == BEQ) q.push_back(SBeq);
    return q;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [1:0] aop, input logic op5,
                                         input logic [2:0] f3, input logic f7);
    if (aop == 2'd0) return 3'b010;
    if (aop == 2'd1) return 3'b110;
    if (aop != 2'd2) return 3'b010;
    if (f3 == 3'd0) return (op5 && f7) ? 3'b110 : 3'b010;
    if (f3 == 3'd2) return 3'b111;
    if (f3 == 3'd6) return 3'b001;
    if (f3 == 3'd7) return 3'b000;
    return 3'b010;
  endfunction

  function automatic outs_t model(input step_t s, input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input logic rst);
    outs_t      e;
    logic [1:0] aop;
    e   = '0;
    aop = 2'd0;
    e.immsrc = (o == SW) ? 2'b01 : (o == BEQ) ? 2'b10 : (o == JAL) ? 2'b11 : 2'b00;
    if (rst) begin
      e.resultsrc  = 2'b10;
      e.alusrcb    = 2'b10;
      e.alucontrol = 3'b010;
      return e;
    end
    case (s)
      SFetch:    begin e.irwrite = 1; e.alusrcb = 2; e.resultsrc = 2; e.pcwrite = 1; end
      SDecode:   begin e.alusrca = 1; e.alusrcb = 1; e.illegal = !legal(o); end
      SMemAdr:   begin e.alusrca = 2; e.alusrcb = 1; end
      SMemRead:  e.adrsrc = 1;
      SMemWb:    begin e.resultsrc = 1; e.regwrite = 1; end
      SMemWrite: begin e.adrsrc = 1; e.memwrite = 1; end
      SExecR:    begin e.alusrca = 2; aop = 2; end
      SExecI:    begin e.alusrca = 2; e.alusrcb = 1; aop = 2; end
      SAluWb:    e.regwrite = 1;
      SBeq:      begin e.alusrca = 2; aop = 1; e.pcwrite = z; end
      SJal:      begin e.alusrca = 1; e.alusrcb = 2; e.pcwrite = 1; end
      default:   ;
    endcase
    e.alucontrol = alu_ref(aop, o[5], f3, f7);
    return e;
  endfunction

  // Drives one cycle's inputs on the falling edge and samples the outputs shortly after.
  task automatic apply(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input logic rst, output outs_t obs);
    @(negedge clk);
    op = o; funct3 = f3; funct7b5 = f7; zero = z; reset = rst;
    #1;
    obs = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb, immsrc,
           regwrite, alucontrol, illegal};
  endtask

  task automatic test_reset();
    outs_t obs, exp;
    stepq_t q;
    for (int i = 0; i < 2; i++) begin
      apply(RT, 3'd0, 1'b0, 1'b1, 1'b1, obs);
      exp = model(SFetch, RT, 3'd0, 1'b0, 1'b1, 1'b1);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset cycle %0d: got %h expected %h", i, obs, exp);
      end
    end
    q = steps_of(RT);
    foreach (q[i]) begin
      apply(RT, 3'd0, 1'b0, 1'b0, 1'b0, obs);
      exp = model(q[i], RT, 3'd0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_release_add step %0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0] ol[6] = '{RT, RT, IT, RT, RT, IT};
    logic [2:0] fl[6] = '{3'd0, 3'd0, 3'd0, 3'd2, 3'd6, 3'd7};
    logic       gl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    outs_t      obs, exp;
    stepq_t     q;
    for (int k = 0; k < 6; k++) begin
      q = steps_of(ol[k]);
      foreach (q[i]) begin
        apply(ol[k], fl[k], gl[k], 1'b0, 1'b0, obs);
        exp = model(q[i], ol[k], fl[k], gl[k], 1'b0, 1'b0);
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL alu_ops[%0d] step %0d: got %h expected %h", k, i, obs, exp);
        end
      end
    end
  endtask

  task automatic test_mem_branch();
    logic [6:0] ol[4] = '{LW, SW, BEQ, BEQ};
    logic       zl[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    outs_t      obs, exp;
    stepq_t     q;
    for (int k = 0; k < 4; k++) begin
      q = steps_of(ol[k]);
      foreach (q[i]) begin
        apply(ol[k], 3'd2, 1'b0, zl[k], 1'b0, obs);
        exp = model(q[i], ol[k], 3'd2, 1'b0, zl[k], 1'b0);
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL mem_branch[%0d] step %0d: got %h expected %h", k, i, obs, exp);
        end
      end
    end
  endtask

  task automatic test_illegal_and_abort();
    logic [6:0] ol[3] = '{7'b1111111, SW, RT};
    int         nstep[3] = '{2, 3, 4};
    outs_t      obs, exp;
    stepq_t     q;
    for (int k = 0; k < 3; k++) begin
      q = steps_of(ol[k]);
      for (int i = 0; i < nstep[k]; i++) begin
        apply(ol[k], 3'd0, 1'b0, 1'b1, 1'b0, obs);
        exp = model(q[i], ol[k], 3'd0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL illegal_abort[%0d] step %0d: got %h expected %h", k, i, obs, exp);
        end
      end
      // sw is cut short: reset lands in what would be MEMWRITE.
      if (ol[k] == SW) begin
        apply(SW, 3'd0, 1'b0, 1'b1, 1'b1, obs);
        exp = model(SFetch, SW, 3'd0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL reset_in_memwrite: got %h expected %h", obs, exp);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] pool[6] = '{LW, SW, RT, IT, BEQ, JAL};
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7, z;
    outs_t      obs, exp;
    stepq_t     q;
    for (int k = 0; k < 80; k++) begin
      o  = ($urandom_range(0, 7) == 0) ? 7'($urandom) : pool[$urandom_range(0, 5)];
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      z  = 1'($urandom);
      q  = steps_of(o);
      foreach (q[i]) begin
        apply(o, f3, f7, z, 1'b0, obs);
        exp = model(q[i], o, f3, f7, z, 1'b0);
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL random[%0d] op=%b step %0d: got %h expected %h", k, o, i, obs, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mem_branch();
    test_illegal_and_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
